iqmap_bpsk: RTL
===============

# iqmap_bpsk

BPSK symbol mapper for the transmit path: accepts 128-bit words from the upstream reader and serializes them LSB-first into one signed I/Q sample per clock-enable. Bit 1 maps to +AMP and bit 0 to -AMP on I; Q is always 0. A one-word holding register allows back-to-back words with no symbol gap. The block sits between the packet reader and the transmit pulse-shaping filter.

## Interface
- AMP, 11'sd256, magnitude of the I sample; legal range 1..1023.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-low.
- ce  in  1  clock enable / symbol strobe; all state and outputs update only when ce=1.
- valid_i  in  1  upstream word valid.
- reader_data  in  128  word to transmit; bit 0 transmitted first.
- ready_o  out  1  registered; high when the holding register is empty.
- valid_o  out  1  registered; ar/ai carry a valid symbol.
- ar  out  11 signed  I sample, +AMP or -AMP.
- ai  out  11 signed  Q sample, always 0.
- last_o  out  1  registered; high with the symbol carrying bit 127 of a word.

## Operation
- Word accept: ce & valid_i & ready_o. reader_data is latched into hold; hold_full set; ready_o drops on the next edge.
- ready_o = !hold_full, registered. Accept and hold-drain never coincide in one cycle.
- States: s_idle, s_active (one-hot, 2 bits). 7-bit counter cnt, 128-bit shift register sh.
- s_idle, ce=1:
  - If hold_full: sh <= hold, hold_full <= 0, cnt <= 0, -> s_active.
  - valid_o <= 0, last_o <= 0; ar/ai hold their last value.
- s_active, ce=1:
  - valid_o <= 1; ar <= sh[0] ? AMP : -AMP; ai <= 0; last_o <= (cnt == 127).
  - sh <= sh >> 1; cnt <= cnt + 1, wrapping 127 -> 0.
  - When cnt == 127:
    - If hold_full: sh <= hold, hold_full <= 0, stay in s_active. The next ce emits the new word's bit 0 with no gap.
    - Otherwise: -> s_idle.
- ce=0: every register, including all outputs, holds.
- Reset (RST=0 on an edge, regardless of ce): state s_idle, cnt 0, hold_full 0, ready_o 1, valid_o 0, last_o 0, ar 0, ai 0. A mid-word reset discards both the partial word and the held word; no further symbols of either are emitted. sh and hold contents are don't-care after reset.
- -AMP is computed as the 11-bit two's complement of AMP; it cannot overflow for legal AMP.

## Timing
- Latency, all counted in ce cycles:
  - Word accepted at edge k (block idle, hold empty).
  - sh is loaded at edge k+1.
  - The first symbol (bit 0) is registered on valid_o/ar at edge k+2.
- Throughput: one symbol per ce cycle; 128 ce cycles per word; continuous output while upstream keeps hold filled.
- ready_o reasserts at the ce edge where hold moves into sh. Upstream therefore has 127 ce cycles to present the next word before a gap forms.
- last_o and valid_o are coincident with the bit-127 symbol. valid_o falls on the following ce edge when no word is pending.

## Structure
- Shared comm package holds:
  - state encodings s_idle/s_active;
  - WORD_W = 128 and CNT_W = 7;
  - the SAMPLE_W = 11 sample width, common with the receive-side demapper.
- Single flat module; no sub-module. The hold register and handshake are too small to justify a separate skid-buffer instance.

## Test plan
- Reset: hold RST=0 for 3 cycles with valid_i=1 -> ready_o=1, valid_o=0, ar=0, ai=0, last_o=0. No word is accepted while RST=0.
- Single word 128'h...0005, ce=1, AMP=256 -> starting 2 cycles after accept, ar = +256, -256, +256, then 125 x -256. ai=0 throughout. last_o high only on the 128th symbol. valid_o low the cycle after.
- Back-to-back: two words presented with valid_i held high -> 256 consecutive valid_o=1 symbols. ready_o low from the cycle after the second accept until the first word's bit-127 symbol edge.
- ce gating: ce toggled 1,0,0,1 during a word -> outputs frozen while ce=0. Symbol sequence identical to the ce=1 run, only stretched in time.
- Mid-word reset after 40 symbols with a word pending in hold -> valid_o=0 and ready_o=1 after the reset edge. A new word 128'h1 then produces +256 first, -256 thereafter.
- Loopback: output drives the BPSK demapper (valid_i=valid_o, ar) with random words -> each recovered 128-bit word equals the transmitted one.

Source files
------------

// File: rtl/iqmap_bpsk_pkg.sv
// Shared comm definitions for the BPSK mapper: state encodings, word/counter
// geometry and the I/Q sample width used by both transmit and receive sides.
package iqmap_bpsk_pkg;

   localparam int WORD_W   = 128;
   localparam int CNT_W    = 7;
   localparam int SAMPLE_W = 11;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

   typedef enum logic [1:0] {
      s_idle   = 2'b01,
      s_active = 2'b10
   } state_t;

endpackage

// File: rtl/iqmap_bpsk_if.sv
// Word handshake from the packet reader and the I/Q symbol stream toward the
// pulse-shaping filter, bundled as one interface.
interface iqmap_bpsk_if;
   import iqmap_bpsk_pkg::*;

   logic                       valid_i;
   logic [WORD_W-1:0]          reader_data;
   logic                       ready_o;
   logic                       valid_o;
   logic signed [SAMPLE_W-1:0] ar;
   logic signed [SAMPLE_W-1:0] ai;
   logic                       last_o;

   modport master (
      output valid_i, reader_data,
      input  ready_o, valid_o, ar, ai, last_o
   );

   modport slave (
      input  valid_i, reader_data,
      output ready_o, valid_o, ar, ai, last_o
   );

endinterface

// File: rtl/iqmap_bpsk.sv
// BPSK mapper: serializes 128-bit words LSB-first into +/-AMP I samples (Q = 0),
// one symbol per ce strobe, with a one-word holding register for gapless streaming.
module iqmap_bpsk
   import iqmap_bpsk_pkg::*;
#(
   parameter logic signed [SAMPLE_W-1:0] AMP = 11'sd256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ce,
   iqmap_bpsk_if.slave bus
);

   state_t                     state;
   state_t                     state_nx;
   logic [CNT_W-1:0]           cnt;
   logic [WORD_W-1:0]          hold;
   logic [WORD_W-1:0]          sh_p0;
   logic                       hold_full;
   logic                       ready;
   logic                       accept;
   logic                       drain;
   logic                       emit;
   logic                       at_last;
   logic signed [SAMPLE_W-1:0] ar_p1;
   logic signed [SAMPLE_W-1:0] ai_p1;
   logic                       vld_p1;
   logic                       last_p1;

   function automatic logic signed [SAMPLE_W-1:0] bpsk_level(input logic b);
      return b ? AMP : -AMP;
   endfunction

   // ready mirrors !hold_full, so an accept and a drain can never share a cycle
   assign accept  = ce & bus.valid_i & ready;
   assign at_last = (cnt == CNT_LAST);

   always_ff @(posedge CLK) begin
      if (!RST) state <= s_idle;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      drain    = 1'b0;
      emit     = 1'b0;
      if (ce) begin
         case (state)
            s_idle: begin
               if (hold_full) begin
                  drain    = 1'b1;
                  state_nx = s_active;
               end
            end
            s_active: begin
               emit = 1'b1;
               if (at_last) begin
                  if (hold_full) drain    = 1'b1;
                  else           state_nx = s_idle;
               end
            end
            default: state_nx = s_idle;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         hold_full <= 1'b0;
         ready     <= 1'b1;
         cnt       <= '0;
      end else begin
         if (accept) begin
            hold_full <= 1'b1;
            ready     <= 1'b0;
         end else if (drain) begin
            hold_full <= 1'b0;
            ready     <= 1'b1;
         end
         // wraps 127 -> 0 on its own, which lines up with a gapless reload
         if (emit)       cnt <= cnt + 1'b1;
         else if (drain) cnt <= '0;
      end
   end

   // Stage p0: holding register and bit shifter (contents don't-care after reset)
   always_ff @(posedge CLK) begin
      if (accept)    hold <= bus.reader_data;
      if (drain)     sh_p0 <= hold;
      else if (emit) sh_p0 <= sh_p0 >> 1;
   end

   // Stage p1: registered symbol outputs
   always_ff @(posedge CLK) begin
      if (!RST) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         ar_p1   <= '0;
         ai_p1   <= '0;
      end else if (ce) begin
         vld_p1  <= emit;
         last_p1 <= emit & at_last;
         if (emit) begin
            ar_p1 <= bpsk_level(sh_p0[0]);
            ai_p1 <= '0;
         end
      end
   end

   assign bus.ready_o = ready;
   assign bus.valid_o = vld_p1;
   assign bus.last_o  = last_p1;
   assign bus.ar      = ar_p1;
   assign bus.ai      = ai_p1;

endmodule
